// File: rtl/aura16_pkg.sv
// aura16_pkg: shared constants and types for the register-file write path.
//   DATA_W     register data width
//   ADDR_W     register address width
//   NREG       number of architectural registers (2**ADDR_W)
//   reg_addr_t register address type
//   reg_data_t register data type
//   ZERO_REG   address of the hardwired-zero register r0
package aura16_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for long-latency writebacks.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous reset, active-high (clears all bits)
//   set_en   in   decode issued a long-latency op
//   set_reg  in   destination of that op
//   clr_en   in   multi-cycle writeback transferred this cycle
//   clr_reg  in   destination of that writeback
//   busy     out  bit i = register i has a pending writeback (registered)
// A set and a clear of the same register in one cycle leave the bit set:
// the newly issued op is still outstanding. Register 0 is never busy.
module rf_scoreboard
  import aura16_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_addr_t       set_reg,
  input  logic            clr_en,
  input  reg_addr_t       clr_reg,
  output logic [NREG-1:0] busy
);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    if (gi == 0) begin : g_zero
      assign busy[gi] = 1'b0;
    end else begin : g_flag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          busy[gi] <= 1'b0;
        end else if (set_en && (set_reg == reg_addr_t'(gi))) begin
          busy[gi] <= 1'b1;
        end else if (clr_en && (clr_reg == reg_addr_t'(gi))) begin
          busy[gi] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates the single register-file write port between the
// in-order pipeline writeback (P) and the multi-cycle unit writeback (M).
// Optional feature macro: WB_BYPASS_EN (adds byp_valid/byp_reg/byp_data).
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   p_valid/p_reg/p_data      pipeline writeback request; p_ready = accepted
//   m_valid/m_reg/m_data      multi-cycle writeback request; m_ready = accepted
//   sb_set/sb_reg             decode marks a register as pending
//   rf_we/rf_waddr/rf_wdata   registered register-file write port
//   byp_valid/byp_reg/byp_data  (WB_BYPASS_EN) current-cycle winning write
//   busy                      scoreboard of pending M writebacks
// P normally wins; after STARVE_MAX consecutive refused M cycles, M is forced.
module rf_wb_arbiter
  import aura16_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_valid,
  input  reg_addr_t       p_reg,
  input  reg_data_t       p_data,
  output logic            p_ready,
  input  logic            m_valid,
  input  reg_addr_t       m_reg,
  input  reg_data_t       m_data,
  output logic            m_ready,
  input  logic            sb_set,
  input  reg_addr_t       sb_reg,
  output logic            rf_we,
  output reg_addr_t       rf_waddr,
  output reg_data_t       rf_wdata,
`ifdef WB_BYPASS_EN
  output logic            byp_valid,
  output reg_addr_t       byp_reg,
  output reg_data_t       byp_data,
`endif
  output logic [NREG-1:0] busy
);

  localparam int STARVE_W = 3;

  logic [STARVE_W-1:0] starve_cnt_reg;
  logic [STARVE_W-1:0] starve_cnt_next;
  logic                force_m;
  logic                p_xfer;
  logic                m_xfer;
  logic                win_valid;
  reg_addr_t           win_reg;
  reg_data_t           win_data;

  assign force_m = (starve_cnt_reg == STARVE_W'(STARVE_MAX));
  // Readies depend only on the other side's valid and the counter, never on
  // the requester's own payload; the two grants are mutually exclusive.
  assign p_ready = !(force_m && m_valid);
  assign m_ready = !p_valid || force_m;
  assign p_xfer  = p_valid && p_ready;
  assign m_xfer  = m_valid && m_ready;

  always_comb begin
    win_valid = 1'b0;
    win_reg   = ZERO_REG;
    win_data  = '0;
    if (m_xfer) begin
      win_valid = 1'b1;
      win_reg   = m_reg;
      win_data  = m_data;
    end else if (p_xfer) begin
      win_valid = 1'b1;
      win_reg   = p_reg;
      win_data  = p_data;
    end
  end

  // Counts consecutive refused M cycles; any gap in m_valid restarts the count.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!m_valid || m_xfer) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_W'(STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Write stage: r0 transfers are accepted but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= ZERO_REG;
      rf_wdata <= '0;
    end else begin
      rf_we <= win_valid && (win_reg != ZERO_REG);
      if (win_valid) begin
        rf_waddr <= win_reg;
        rf_wdata <= win_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = win_valid && (win_reg != ZERO_REG);
  assign byp_reg   = win_reg;
  assign byp_data  = win_data;
`endif

  rf_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set),
    .set_reg (sb_reg),
    .clr_en  (m_xfer),
    .clr_reg (m_reg),
    .busy    (busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with hand-computed expectations.
// Stimulus pushes each expected register-file write into a queue; a monitor
// pops and compares whenever rf_we is seen high.
module tb_rf_wb_arbiter;
  import aura16_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            p_valid, m_valid, sb_set;
  reg_addr_t       p_reg, m_reg, sb_reg;
  reg_data_t       p_data, m_data;
  logic            p_ready, m_ready;
  logic            rf_we;
  reg_addr_t       rf_waddr;
  reg_data_t       rf_wdata;
  logic [NREG-1:0] busy;
`ifdef WB_BYPASS_EN
  logic            byp_valid;
  reg_addr_t       byp_reg;
  reg_data_t       byp_data;
`endif

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .p_valid  (p_valid),
    .p_reg    (p_reg),
    .p_data   (p_data),
    .p_ready  (p_ready),
    .m_valid  (m_valid),
    .m_reg    (m_reg),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .sb_set   (sb_set),
    .sb_reg   (sb_reg),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
`ifdef WB_BYPASS_EN
    .byp_valid(byp_valid),
    .byp_reg  (byp_reg),
    .byp_data (byp_data),
`endif
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h expected none", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          bad++;
          $display("FAIL wr_cmp: got addr=%0d data=%h expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end else begin
          $display("wr   addr=%0d data=%h", rf_waddr, rf_wdata);
        end
      end
    end
  end

  // Called at posedge+1: drive one cycle, check readies, queue the expected
  // write of the winner, then return at posedge+1 of the following cycle.
  task automatic cyc(input string name,
                     input logic pv, input reg_addr_t pr, input reg_data_t pd,
                     input logic mv, input reg_addr_t mr, input reg_data_t md,
                     input logic ss, input reg_addr_t sr,
                     input logic exp_pr, input logic exp_mr, input logic push);
    p_valid = pv; p_reg = pr; p_data = pd;
    m_valid = mv; m_reg = mr; m_data = md;
    sb_set  = ss; sb_reg = sr;
    #1;
    chk({name, "_p_ready"}, 32'(p_ready), 32'(exp_pr));
    chk({name, "_m_ready"}, 32'(m_ready), 32'(exp_mr));
    if (push) begin
      if (mv && exp_mr && mr != 0) exp_q.push_back('{addr: mr, data: md});
      else if (pv && exp_pr && pr != 0) exp_q.push_back('{addr: pr, data: pd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc("idle", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
  endtask

  // Contention grant pattern with STARVE_MAX=3: P,P,P,M repeating.
  localparam logic [7:0] CONT_P = 8'b0111_0111; // bit i = cycle i
  localparam logic [7:0] CONT_M = 8'b1000_1000;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] cp, cm;
    cp = CONT_P;
    cm = CONT_M;
    rst = 1'b1;
    p_valid = 0; p_reg = 0; p_data = 0;
    m_valid = 0; m_reg = 0; m_data = 0;
    sb_set = 0; sb_reg = 0;
    #1;
    chk("reset_we",    32'(rf_we),    32'd0);
    chk("reset_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_wdata", 32'(rf_wdata), 32'd0);
    chk("reset_busy",  32'(busy),     32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset mid-write, asynchronous
    cyc("rstw", 1'b1, 3'd3, 16'h3333, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    chk("rstw_we_pre",   32'(rf_we),    32'd1);
    chk("rstw_addr_pre", 32'(rf_waddr), 32'd3);
    chk("rstw_busy_pre", 32'(busy),     32'h40);
    p_valid = 0; sb_set = 0;
    #1 rst = 1'b1;
    #1;
    chk("rstw_we",    32'(rf_we),    32'd0);
    chk("rstw_waddr", 32'(rf_waddr), 32'd0);
    chk("rstw_wdata", 32'(rf_wdata), 32'd0);
    chk("rstw_busy",  32'(busy),     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 2: single P write, then hold
    cyc("p2", 1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    chk("p2_we",    32'(rf_we),    32'd1);
    chk("p2_waddr", 32'(rf_waddr), 32'd2);
    chk("p2_wdata", 32'(rf_wdata), 32'hBEEF);
    idle();
    chk("p2_we_off",   32'(rf_we),    32'd0);
    chk("p2_hold_adr", 32'(rf_waddr), 32'd2);
    chk("p2_hold_dat", 32'(rf_wdata), 32'hBEEF);

    // 3: continuous contention
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("cont%0d", i), 1'b1, 3'd1, reg_data_t'(16'h1000 + i),
          1'b1, 3'd7, reg_data_t'(16'h7000 + i), 1'b0, 3'd0, cp[i], cm[i], 1'b1);
    end
    idle();

    // starvation count restarts after an m_valid gap
    cyc("gap0", 1'b1, 3'd1, 16'h2000, 1'b1, 3'd6, 16'h6000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc("gap1", 1'b1, 3'd1, 16'h2001, 1'b1, 3'd6, 16'h6001, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc("gap2", 1'b1, 3'd1, 16'h2002, 1'b0, 3'd6, 16'h6002, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc("gap3", 1'b1, 3'd1, 16'h2003, 1'b1, 3'd6, 16'h6003, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc("gap4", 1'b1, 3'd1, 16'h2004, 1'b1, 3'd6, 16'h6004, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc("gap5", 1'b1, 3'd1, 16'h2005, 1'b1, 3'd6, 16'h6005, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc("gap6", 1'b1, 3'd1, 16'h2006, 1'b1, 3'd6, 16'h6006, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();

    // 4: M write to r0 (and an attempted r0 scoreboard set)
    cyc("r0", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    chk("r0_we",   32'(rf_we),   32'd0);
    chk("r0_busy", 32'(busy[0]), 32'd0);

    // 5: scoreboard set / set-wins / clear; P never touches busy
    cyc("sb_set", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
    chk("sb_set_busy", 32'(busy), 32'h20);
    cyc("sb_both", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
    chk("sb_both_busy", 32'(busy), 32'h20);
    cyc("sb_clr", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h5A5A, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    chk("sb_clr_busy", 32'(busy), 32'h00);
    cyc("sb_set3", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
    cyc("sb_p3", 1'b1, 3'd3, 16'h0333, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    chk("sb_p3_busy", 32'(busy), 32'h08);
    idle();

`ifdef WB_BYPASS_EN
    // 6: bypass mirrors the current-cycle winner
    p_valid = 1'b1; p_reg = 3'd4; p_data = 16'h00AA;
    m_valid = 1'b0; sb_set = 1'b0;
    #1;
    chk("byp_valid", 32'(byp_valid), 32'd1);
    chk("byp_reg",   32'(byp_reg),   32'd4);
    chk("byp_data",  32'(byp_data),  32'h00AA);
    exp_q.push_back('{addr: 3'd4, data: 16'h00AA});
    @(posedge clk); #1;
    chk("byp_we", 32'(rf_we), 32'd1);
    idle();
`endif

    @(posedge clk); @(posedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
